// File: rtl/video_mnist_result_capture.sv
// video_mnist_result_capture
//   Consumes the per-pixel classification stream from the MNIST CNN and builds
//   per-frame statistics: a class histogram, a reject count, a line count and a
//   pixel count. At every frame boundary the live counters are copied into a
//   shadow bank. The CPU reads the shadow bank over a Wishbone responder.
// Ports
//   aclk, aresetn     : single clock, asynchronous active-low reset
//   s_axi4s_*         : classifier stream sink (tuser[0]=SOF, tlast=EOL); never stalls
//   s_wb_*            : Wishbone responder with registered single-cycle ack
//   frame_irq         : one-cycle pulse after the shadow bank updates
module video_mnist_result_capture #(
   parameter int   NUM_CLASS       = 11,
   parameter int   TUSER_WIDTH     = 1,
   parameter int   TNUMBER_WIDTH   = 4,
   parameter int   TCOUNT_WIDTH    = 4,
   parameter int   COUNT_WIDTH     = 24,
   parameter int   WB_ADR_WIDTH    = 8,
   parameter int   WB_DAT_WIDTH    = 32,
   parameter int   WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
   parameter logic INIT_CTL_ENABLE = 1'b1,
   parameter int   INIT_COUNT_TH   = 7
) (
   input  logic                     aresetn,
   input  logic                     aclk,
   input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
   input  logic                     s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
   input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
   input  logic                     s_axi4s_tvalid,
   output logic                     s_axi4s_tready,
   input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
   input  logic                     s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
   input  logic                     s_wb_stb_i,
   output logic                     s_wb_ack_o,
   output logic                     frame_irq
);

   typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;

   typedef struct packed {
      logic [NUM_CLASS-1:0][COUNT_WIDTH-1:0] hist;
      logic [COUNT_WIDTH-1:0]                line;
      logic [COUNT_WIDTH-1:0]                pix;
      logic [COUNT_WIDTH-1:0]                rej;
   } stats_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                      input logic en);
      return (en && v != CNT_MAX) ? v + COUNT_WIDTH'(1) : v;
   endfunction

   state_t                   state_q, state_d;
   logic                     state_run;
   logic                     tready_q;
   logic                     enable_q, enable_d;
   logic [TCOUNT_WIDTH-1:0]  th_q, th_d;
   logic [31:0]              frame_cnt_q, frame_cnt_d;
   logic                     valid_q, valid_d;
   logic                     irq_q, irq_d;
   logic                     ack_q, ack_d;
   logic [WB_DAT_WIDTH-1:0]  dat_q, dat_d;
   stats_t                   act_q, act_d, shd_q, shd_d;

   logic                     wb_new, wb_wr, ctl_wr, clear, dis_wr, hold;
   logic                     accept, sof, arm, boundary, count_beat, hit;
   logic [WB_DAT_WIDTH-1:0]  wmask, rdata;
   logic                     unused_bits;

   // ---------------- control decode ----------------
   always_comb begin
      wmask = '0;
      for (int b = 0; b < WB_SEL_WIDTH; b++) wmask[b*8 +: 8] = {8{s_wb_sel_i[b]}};
   end

   assign wb_new = s_wb_stb_i & ~ack_q;           // strobe sampled, ack next cycle
   assign wb_wr  = s_wb_stb_i & s_wb_we_i & ack_q; // write commits in the ack cycle
   assign ctl_wr = wb_wr && (s_wb_adr_i == WB_ADR_WIDTH'(1));
   assign clear  = ctl_wr & s_wb_sel_i[0] & s_wb_dat_i[1];
   assign dis_wr = ctl_wr & s_wb_sel_i[0] & ~s_wb_dat_i[0];
   // clear or disable overrides any stream activity in the same cycle
   assign hold   = clear | dis_wr;

   assign accept     = s_axi4s_tvalid & tready_q;
   assign sof        = accept & s_axi4s_tuser[0];
   assign arm        = (state_q == WAIT_SOF) & sof & enable_q & ~hold;
   assign boundary   = (state_q == RUN) & sof & ~hold;
   assign count_beat = ((state_q == RUN) & accept & ~hold) | arm;
   assign hit        = (s_axi4s_tcount >= th_q) && (int'(s_axi4s_tnumber) < NUM_CLASS);

   assign unused_bits = ^{s_wb_dat_i, wmask, s_axi4s_tuser};

   // ---------------- FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= WAIT_SOF;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (hold)     state_d = WAIT_SOF;
      else if (arm) state_d = RUN;
   end

   always_comb begin
      state_run = (state_q == RUN);
   end

   // ---------------- statistics datapath ----------------
   always_comb begin
      act_d       = act_q;
      shd_d       = shd_q;
      frame_cnt_d = frame_cnt_q;
      valid_d     = valid_q;
      irq_d       = boundary;
      if (wb_new && !s_wb_we_i && s_wb_adr_i == WB_ADR_WIDTH'(4)) valid_d = 1'b0;
      // boundary sets valid after the read-clear so it wins a same-cycle race
      if (boundary) begin
         shd_d       = act_q;
         frame_cnt_d = frame_cnt_q + 32'd1;
         valid_d     = 1'b1;
      end
      if (clear) begin
         act_d       = '0;
         frame_cnt_d = '0;
      end else if (count_beat) begin
         // a new frame restarts from zero with its SOF beat as first pixel
         if (arm | boundary) act_d = '0;
         act_d.pix  = sat_inc(act_d.pix, 1'b1);
         act_d.line = sat_inc(act_d.line, s_axi4s_tlast);
         act_d.rej  = sat_inc(act_d.rej, ~hit);
         for (int n = 0; n < NUM_CLASS; n++)
            act_d.hist[n] = sat_inc(act_d.hist[n], hit && (int'(s_axi4s_tnumber) == n));
      end
   end

   // ---------------- Wishbone registers ----------------
   always_comb begin
      enable_d = enable_q;
      th_d     = th_q;
      if (ctl_wr && s_wb_sel_i[0]) enable_d = s_wb_dat_i[0];
      if (wb_wr && s_wb_adr_i == WB_ADR_WIDTH'(2))
         th_d = (th_q & ~wmask[TCOUNT_WIDTH-1:0]) |
                (s_wb_dat_i[TCOUNT_WIDTH-1:0] & wmask[TCOUNT_WIDTH-1:0]);
   end

   always_comb begin
      rdata = '0;
      case (s_wb_adr_i)
         WB_ADR_WIDTH'(0): rdata = WB_DAT_WIDTH'(32'h5254_4301);
         WB_ADR_WIDTH'(1): rdata = WB_DAT_WIDTH'(enable_q);
         WB_ADR_WIDTH'(2): rdata = WB_DAT_WIDTH'(th_q);
         WB_ADR_WIDTH'(3): rdata = WB_DAT_WIDTH'(frame_cnt_q);
         WB_ADR_WIDTH'(4): rdata = WB_DAT_WIDTH'({state_run, valid_q});
         WB_ADR_WIDTH'(5): rdata = WB_DAT_WIDTH'(shd_q.line);
         WB_ADR_WIDTH'(6): rdata = WB_DAT_WIDTH'(shd_q.pix);
         WB_ADR_WIDTH'(7): rdata = WB_DAT_WIDTH'(shd_q.rej);
         default: begin
            for (int n = 0; n < NUM_CLASS; n++)
               if (s_wb_adr_i == WB_ADR_WIDTH'(16 + n)) rdata = WB_DAT_WIDTH'(shd_q.hist[n]);
         end
      endcase
      ack_d = wb_new;
      dat_d = (wb_new && !s_wb_we_i) ? rdata : '0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tready_q    <= 1'b0;
         enable_q    <= INIT_CTL_ENABLE;
         th_q        <= TCOUNT_WIDTH'(INIT_COUNT_TH);
         frame_cnt_q <= '0;
         valid_q     <= 1'b0;
         irq_q       <= 1'b0;
         ack_q       <= 1'b0;
         dat_q       <= '0;
         act_q       <= '0;
         shd_q       <= '0;
      end else begin
         tready_q    <= 1'b1;
         enable_q    <= enable_d;
         th_q        <= th_d;
         frame_cnt_q <= frame_cnt_d;
         valid_q     <= valid_d;
         irq_q       <= irq_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
         act_q       <= act_d;
         shd_q       <= shd_d;
      end
   end

   assign s_axi4s_tready = tready_q;
   assign s_wb_ack_o     = ack_q;
   assign s_wb_dat_o     = dat_q;
   assign frame_irq      = irq_q;

endmodule

// File: tb/tb_video_mnist_result_capture.sv
// Bench for video_mnist_result_capture: directed sequence with randomized pixel
// content, checked against a beat-level reference model of the statistics.
module tb_video_mnist_result_capture;
   localparam int NC = 11;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [0:0]  s_axi4s_tuser = '0;
   logic        s_axi4s_tlast = 1'b0;
   logic [3:0]  s_axi4s_tnumber = '0;
   logic [3:0]  s_axi4s_tcount = '0;
   logic        s_axi4s_tvalid = 1'b0;
   logic        s_axi4s_tready;
   logic [7:0]  s_wb_adr_i = '0;
   logic [31:0] s_wb_dat_i = '0;
   logic [31:0] s_wb_dat_o;
   logic        s_wb_we_i = 1'b0;
   logic [3:0]  s_wb_sel_i = '0;
   logic        s_wb_stb_i = 1'b0;
   logic        s_wb_ack_o;
   logic        frame_irq;

   video_mnist_result_capture dut (
      .aresetn(aresetn), .aclk(aclk),
      .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
      .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
      .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
      .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
      .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
      .s_wb_ack_o(s_wb_ack_o), .frame_irq(frame_irq)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;
   int irq_cnt = 0;

   always @(posedge aclk) if (frame_irq) irq_cnt <= irq_cnt + 1;

   // reference model state
   bit m_run, m_en, m_valid;
   int m_th, m_frames;
   int a_pix, a_line, a_rej, a_hist[NC];
   int s_pix, s_line, s_rej, s_hist[NC];
   logic [3:0] pn[64];
   logic [3:0] pc[64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic zero_act();
      a_pix = 0; a_line = 0; a_rej = 0;
      for (int n = 0; n < NC; n++) a_hist[n] = 0;
   endtask

   task automatic model_reset();
      m_run = 0; m_en = 1; m_valid = 0; m_th = 7; m_frames = 0;
      zero_act();
      s_pix = 0; s_line = 0; s_rej = 0;
      for (int n = 0; n < NC; n++) s_hist[n] = 0;
   endtask

   task automatic model_count(input bit tl, input int num, input int cnt);
      a_pix++;
      if (cnt >= m_th && num < NC) a_hist[num]++;
      else a_rej++;
      if (tl) a_line++;
   endtask

   // one beat, one cycle; model decides what the beat means and whether irq follows
   task automatic beat(input bit tu, input bit tl, input logic [3:0] num, input logic [3:0] cnt);
      bit exp_irq;
      s_axi4s_tvalid = 1'b1; s_axi4s_tuser = tu; s_axi4s_tlast = tl;
      s_axi4s_tnumber = num; s_axi4s_tcount = cnt;
      @(posedge aclk); #1;
      s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
      exp_irq = 0;
      if (!m_run) begin
         if (tu && m_en) begin
            m_run = 1; zero_act(); model_count(tl, int'(num), int'(cnt));
         end
      end else begin
         if (tu) begin
            s_pix = a_pix; s_line = a_line; s_rej = a_rej;
            for (int n = 0; n < NC; n++) s_hist[n] = a_hist[n];
            m_frames++; m_valid = 1; exp_irq = 1; zero_act();
         end
         model_count(tl, int'(num), int'(cnt));
      end
      check("frame_irq", {31'd0, frame_irq}, {31'd0, exp_irq});
   endtask

   task automatic send_frame(input int w, input int h);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            beat(y == 0 && x == 0, x == w - 1, pn[y*w+x], pc[y*w+x]);
   endtask

   task automatic wb(input bit we, input logic [7:0] adr, input logic [31:0] wd,
                     input logic [3:0] sel, output logic [31:0] rd);
      s_wb_adr_i = adr; s_wb_dat_i = wd; s_wb_sel_i = sel; s_wb_we_i = we; s_wb_stb_i = 1'b1;
      @(posedge aclk); #1;
      check("ack_rise", {31'd0, s_wb_ack_o}, 32'd1);
      rd = s_wb_dat_o;
      @(posedge aclk); #1;
      s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
      check("ack_fall", {31'd0, s_wb_ack_o}, 32'd0);
   endtask

   task automatic wr(input logic [7:0] adr, input logic [31:0] wd, input logic [3:0] sel);
      logic [31:0] r;
      wb(1'b1, adr, wd, sel, r);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] adr, input logic [31:0] exp);
      logic [31:0] r;
      wb(1'b0, adr, 32'd0, 4'hf, r);
      check(tag, r, exp);
      if (adr == 8'h04) m_valid = 0;
   endtask

   task automatic check_shadow();
      rd_chk("line_count", 8'h05, 32'(s_line));
      rd_chk("pixel_count", 8'h06, 32'(s_pix));
      rd_chk("reject_count", 8'h07, 32'(s_rej));
      for (int n = 0; n < NC; n++) rd_chk($sformatf("hist%0d", n), 8'(16 + n), 32'(s_hist[n]));
      rd_chk("frame_count", 8'h03, 32'(m_frames));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, h, p10, p15, th;
      model_reset();
      #2;
      check("rst_tready", {31'd0, s_axi4s_tready}, 32'd0);
      check("rst_ack", {31'd0, s_wb_ack_o}, 32'd0);
      check("rst_irq", {31'd0, frame_irq}, 32'd0);
      check("rst_dat", s_wb_dat_o, 32'd0);
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      check("tready_pre", {31'd0, s_axi4s_tready}, 32'd0);
      @(posedge aclk); #1;
      check("tready_post", {31'd0, s_axi4s_tready}, 32'd1);

      rd_chk("core_id", 8'h00, 32'h5254_4301);
      rd_chk("th_reset", 8'h02, 32'd7);
      rd_chk("frame_reset", 8'h03, 32'd0);
      rd_chk("status_reset", 8'h04, 32'd0);
      rd_chk("unmapped", 8'h08, 32'd0);

      // beats before the first SOF must be ignored
      for (int i = 0; i < 5; i++) beat(1'b0, 1'($urandom_range(0, 1)), 4'(3), 4'(9));
      for (int i = 0; i < 32; i++) begin pn[i] = 4'd3; pc[i] = 4'd9; end
      send_frame(8, 4);
      send_frame(8, 4);
      beat(1'b1, 1'b0, 4'd3, 4'd9);
      rd_chk("hist3_uniform", 8'h13, 32'd32);
      rd_chk("pixel_uniform", 8'h06, 32'd32);
      rd_chk("line_uniform", 8'h05, 32'd4);
      rd_chk("reject_uniform", 8'h07, 32'd0);
      rd_chk("frames_uniform", 8'h03, 32'd2);
      check("irq_pulses", 32'(irq_cnt), 32'd2);
      check_shadow();
      rd_chk("status_valid_run", 8'h04, 32'd3);
      rd_chk("status_cleared", 8'h04, 32'd2);

      // clear + enable written in the same cycle as an SOF beat
      s_wb_adr_i = 8'h01; s_wb_dat_i = 32'h3; s_wb_sel_i = 4'h1; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
      @(posedge aclk); #1;
      check("clr_ack", {31'd0, s_wb_ack_o}, 32'd1);
      s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b1; s_axi4s_tnumber = 4'd3; s_axi4s_tcount = 4'd9;
      @(posedge aclk); #1;
      s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0;
      check("clr_irq", {31'd0, frame_irq}, 32'd0);
      m_run = 0; m_en = 1; m_frames = 0; zero_act();
      rd_chk("clr_frames", 8'h03, 32'd0);
      rd_chk("clr_status", 8'h04, 32'd0);
      rd_chk("ctl_read", 8'h01, 32'd1);

      wr(8'h01, 32'h0, 4'h1); m_en = 0; m_run = 0;
      beat(1'b1, 1'b0, 4'd3, 4'd9);
      rd_chk("disabled_status", 8'h04, 32'd0);
      wr(8'h01, 32'h1, 4'h1); m_en = 1;
      beat(1'b1, 1'b0, 4'd3, 4'd9);
      rd_chk("rearmed_status", 8'h04, 32'd2);

      // threshold split frame with an out-of-range class
      p10 = 16 + int'($urandom_range(0, 7));
      p15 = 24 + int'($urandom_range(0, 7));
      for (int i = 0; i < 32; i++) begin
         pc[i] = (i < 16) ? 4'd5 : 4'd7;
         pn[i] = 4'($urandom_range(0, 9));
      end
      pn[p10] = 4'd10; pn[p15] = 4'd15;
      send_frame(8, 4);
      beat(1'b1, 1'b0, 4'd0, 4'd0);
      rd_chk("reject_split", 8'h07, 32'd17);
      rd_chk("hist10_split", 8'h1A, 32'd1);
      check_shadow();

      // random threshold, random frames
      for (int k = 0; k < 2; k++) begin
         th = int'($urandom_range(0, 15));
         wr(8'h02, 32'(th), 4'h1); m_th = th;
         rd_chk("th_write", 8'h02, 32'(th));
         wr(8'h02, 32'(~th), 4'h0);
         rd_chk("th_nosel", 8'h02, 32'(th));
         w = int'($urandom_range(1, 8));
         h = int'($urandom_range(1, 4));
         for (int i = 0; i < 32; i++) begin
            pn[i] = 4'($urandom_range(0, 15));
            pc[i] = 4'($urandom_range(0, 15));
         end
         send_frame(w, h);
         beat(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         check_shadow();
      end

      // reset in the middle of a frame and a TH write
      beat(1'b0, 1'b0, 4'd1, 4'd15);
      beat(1'b0, 1'b1, 4'd2, 4'd15);
      s_wb_adr_i = 8'h02; s_wb_dat_i = 32'h3; s_wb_sel_i = 4'hf; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
      @(posedge aclk); #1;
      check("rstw_ack", {31'd0, s_wb_ack_o}, 32'd1);
      aresetn = 1'b0;
      #1;
      check("rstw_ack_drop", {31'd0, s_wb_ack_o}, 32'd0);
      check("rstw_tready", {31'd0, s_axi4s_tready}, 32'd0);
      @(posedge aclk); #1;
      s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      check("rstw_tready_up", {31'd0, s_axi4s_tready}, 32'd1);
      model_reset();
      rd_chk("rstw_th", 8'h02, 32'd7);
      rd_chk("rstw_ctl", 8'h01, 32'd1);
      rd_chk("rstw_status", 8'h04, 32'd0);
      check_shadow();
      for (int i = 0; i < 8; i++) begin pn[i] = 4'd4; pc[i] = 4'd8; end
      send_frame(8, 1);
      beat(1'b1, 1'b0, 4'd4, 4'd8);
      rd_chk("post_rst_pixel", 8'h06, 32'd8);
      check_shadow();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
